// File: rtl/instruction_fetch_memory_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_memory_if
// Description : Program-load stream and fetch bus of the instruction store.
//               master = load/fetch driver, slave = the instruction store.
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_fetch_memory_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  // Program-load stream
  logic                    load_start;
  logic                    load_valid;
  logic [DATA_WIDTH-1:0]   load_data;
  logic                    load_last;
  logic                    load_ready;
  logic [ADDR_WIDTH:0]     words_loaded;
  logic                    loaded;

  // Fetch port
  logic [ADDR_WIDTH+1:0]   fetch_address;
  logic                    fetch_enable;
  logic                    flush;
  logic [DATA_WIDTH-1:0]   data_out;
  logic                    data_valid;
  logic                    fetch_misaligned;

  modport master (
    output load_start, load_valid, load_data, load_last,
    output fetch_address, fetch_enable, flush,
    input  load_ready, words_loaded, loaded,
    input  data_out, data_valid, fetch_misaligned
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last,
    input  fetch_address, fetch_enable, flush,
    output load_ready, words_loaded, loaded,
    output data_out, data_valid, fetch_misaligned
  );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch_memory.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_memory
// Description : Synchronous instruction store. Loaded through a valid/ready
//               word stream with an auto-incrementing pointer, then serves
//               one-cycle-latency fetches by byte PC with stall and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_memory #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 10,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input logic                        system_clock,
  input logic                        reset_n,
  instruction_fetch_memory_if.slave  bus
);

  localparam int                    DEPTH      = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = '1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   WORDS_ONE  = (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [ADDR_WIDTH:0]     words_count;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [DATA_WIDTH-1:0]   data_out_q;
  logic                    data_valid_q;
  logic                    misaligned_q;

  logic                    write_en;
  logic [ADDR_WIDTH-1:0]   word_index;
  logic [1:0]              byte_offset;

  // A beat is accepted only in LOADING; load_start and reset both win over it.
  assign write_en    = reset_n && (state == LOADING) && bus.load_valid && !bus.load_start;
  assign word_index  = bus.fetch_address[ADDR_WIDTH+1:2];
  assign byte_offset = bus.fetch_address[1:0];

  assign bus.load_ready       = (state == LOADING);
  assign bus.loaded           = (state == READY);
  assign bus.words_loaded     = words_count;
  assign bus.data_out         = data_out_q;
  assign bus.data_valid       = data_valid_q;
  assign bus.fetch_misaligned = misaligned_q;

  // Load control: state, write pointer and loaded-word count.
  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      ptr         <= '0;
      words_count <= '0;
    end else if (bus.load_start) begin
      state       <= LOADING;
      ptr         <= '0;
      words_count <= '0;
    end else if (write_en) begin
      words_count <= words_count + WORDS_ONE;
      // The pointer saturates at the top index so the array is never wrapped.
      if (ptr != LAST_INDEX) begin
        ptr <= ptr + PTR_ONE;
      end
      if (bus.load_last || (ptr == LAST_INDEX)) begin
        state <= READY;
      end
    end
  end

  // Instruction array write port; contents deliberately survive reset.
  always_ff @(posedge system_clock) begin
    if (write_en) begin
      mem[ptr] <= bus.load_data;
    end
  end

  // Registered fetch output: flush beats stall, stall holds everything.
  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else if (bus.flush) begin
      data_out_q   <= NOP_WORD;
      data_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else if (bus.fetch_enable) begin
      if (state != READY) begin
        data_out_q   <= NOP_WORD;
        data_valid_q <= 1'b0;
        misaligned_q <= 1'b0;
      end else if (byte_offset != 2'b00) begin
        data_out_q   <= NOP_WORD;
        data_valid_q <= 1'b0;
        misaligned_q <= 1'b1;
      end else begin
        data_out_q   <= mem[word_index];
        data_valid_q <= 1'b1;
        misaligned_q <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_memory
// Description : Self-checking bench for instruction_fetch_memory. Two
//               instances: ADDR_WIDTH=10 (main) and ADDR_WIDTH=2 (overflow).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_memory;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic system_clock = 1'b0;
  logic reset_n      = 1'b0;

  always #5 system_clock = ~system_clock;

  instruction_fetch_memory_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) big_bus ();
  instruction_fetch_memory_if #(.DATA_WIDTH(32), .ADDR_WIDTH(2))  small_bus ();

  instruction_fetch_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .NOP_WORD(NOP)) u_dut_big (
    .system_clock (system_clock),
    .reset_n      (reset_n),
    .bus          (big_bus.slave)
  );

  instruction_fetch_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .NOP_WORD(NOP)) u_dut_small (
    .system_clock (system_clock),
    .reset_n      (reset_n),
    .bus          (small_bus.slave)
  );

  // Scoreboard entry: expected fetch result for one instance.
  typedef struct {
    int          sel;
    logic [31:0] data;
    logic        valid;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  int tests  = 0;
  int failed = 0;

  // Reference model, index 0 = big instance, 1 = small instance.
  int          m_state [2];   // 0 idle, 1 loading, 2 ready
  int          m_ptr   [2];
  int          m_words [2];
  logic [31:0] m_mem   [2][1024];
  logic [31:0] m_out   [2];
  logic        m_valid [2];
  logic        m_mis   [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_data(input int sel);
    return (sel != 0) ? small_bus.data_out : big_bus.data_out;
  endfunction
  function automatic logic rd_valid(input int sel);
    return (sel != 0) ? small_bus.data_valid : big_bus.data_valid;
  endfunction
  function automatic logic rd_mis(input int sel);
    return (sel != 0) ? small_bus.fetch_misaligned : big_bus.fetch_misaligned;
  endfunction
  function automatic logic [31:0] rd_words(input int sel);
    return (sel != 0) ? {29'd0, small_bus.words_loaded} : {21'd0, big_bus.words_loaded};
  endfunction
  function automatic logic rd_loaded(input int sel);
    return (sel != 0) ? small_bus.loaded : big_bus.loaded;
  endfunction
  function automatic logic rd_ready(input int sel);
    return (sel != 0) ? small_bus.load_ready : big_bus.load_ready;
  endfunction

  task automatic drive_load(input int sel, input logic st, input logic vld,
                            input logic [31:0] d, input logic lst);
    if (sel != 0) begin
      small_bus.load_start = st; small_bus.load_valid = vld;
      small_bus.load_data  = d;  small_bus.load_last  = lst;
    end else begin
      big_bus.load_start = st; big_bus.load_valid = vld;
      big_bus.load_data  = d;  big_bus.load_last  = lst;
    end
  endtask

  task automatic drive_fetch(input int sel, input logic [11:0] addr, input logic en, input logic fl);
    if (sel != 0) begin
      small_bus.fetch_address = addr[3:0];
      small_bus.fetch_enable  = en;
      small_bus.flush         = fl;
    end else begin
      big_bus.fetch_address = addr;
      big_bus.fetch_enable  = en;
      big_bus.flush         = fl;
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_state[s] = 0; m_ptr[s] = 0; m_words[s] = 0;
      m_out[s] = 32'h0; m_valid[s] = 1'b0; m_mis[s] = 1'b0;
    end
  endtask

  task automatic model_load(input int sel, input logic st, input logic vld,
                            input logic [31:0] d, input logic lst);
    int max_idx;
    max_idx = (sel != 0) ? 3 : 1023;
    if (st) begin
      m_state[sel] = 1; m_ptr[sel] = 0; m_words[sel] = 0;
    end else if (m_state[sel] == 1 && vld) begin
      m_mem[sel][m_ptr[sel]] = d;
      m_words[sel]++;
      if (lst || m_ptr[sel] == max_idx) m_state[sel] = 2;
      else m_ptr[sel]++;
    end
  endtask

  // Predict the registered fetch result and queue it for the next edge.
  task automatic model_fetch(input int sel, input logic [11:0] addr, input logic en, input logic fl);
    exp_t e;
    if (fl) begin
      m_out[sel] = NOP; m_valid[sel] = 1'b0; m_mis[sel] = 1'b0;
    end else if (en) begin
      if (m_state[sel] != 2) begin
        m_out[sel] = NOP; m_valid[sel] = 1'b0; m_mis[sel] = 1'b0;
      end else if (addr[1:0] != 2'b00) begin
        m_out[sel] = NOP; m_valid[sel] = 1'b0; m_mis[sel] = 1'b1;
      end else begin
        m_out[sel] = m_mem[sel][int'(addr[11:2])]; m_valid[sel] = 1'b1; m_mis[sel] = 1'b0;
      end
    end
    e.sel = sel; e.data = m_out[sel]; e.valid = m_valid[sel]; e.mis = m_mis[sel];
    sb.push_back(e);
  endtask

  // Advance one clock and retire every scoreboard entry due at this edge.
  task automatic step();
    exp_t e;
    @(posedge system_clock);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("fetch_data[%0d]", e.sel),  rd_data(e.sel),         e.data);
      check($sformatf("fetch_valid[%0d]", e.sel), 32'(rd_valid(e.sel)),   32'(e.valid));
      check($sformatf("fetch_mis[%0d]", e.sel),   32'(rd_mis(e.sel)),     32'(e.mis));
    end
  endtask

  task automatic check_status(input int sel);
    check($sformatf("loaded[%0d]", sel),       32'(rd_loaded(sel)), 32'(m_state[sel] == 2));
    check($sformatf("load_ready[%0d]", sel),   32'(rd_ready(sel)),  32'(m_state[sel] == 1));
    check($sformatf("words_loaded[%0d]", sel), rd_words(sel),       32'(m_words[sel]));
  endtask

  task automatic check_hold(input int sel);
    check($sformatf("hold_data[%0d]", sel),  rd_data(sel),        m_out[sel]);
    check($sformatf("hold_valid[%0d]", sel), 32'(rd_valid(sel)),  32'(m_valid[sel]));
    check($sformatf("hold_mis[%0d]", sel),   32'(rd_mis(sel)),    32'(m_mis[sel]));
  endtask

  task automatic load_cycle(input int sel, input logic st, input logic vld,
                            input logic [31:0] d, input logic lst);
    drive_load(sel, st, vld, d, lst);
    model_load(sel, st, vld, d, lst);
    step();
    drive_load(sel, 1'b0, 1'b0, 32'h0, 1'b0);
    check_status(sel);
    check_hold(sel);
  endtask

  task automatic fetch_cycle(input int sel, input logic [11:0] addr, input logic en, input logic fl);
    drive_fetch(sel, addr, en, fl);
    model_fetch(sel, addr, en, fl);
    step();
    drive_fetch(sel, addr, 1'b0, 1'b0);
  endtask

  logic [31:0] prog [4];

  initial begin
    prog[0] = 32'h11; prog[1] = 32'h22; prog[2] = 32'h33; prog[3] = 32'h44;
    for (int s = 0; s < 2; s++) begin
      drive_load(s, 1'b0, 1'b0, 32'h0, 1'b0);
      drive_fetch(s, 12'h0, 1'b0, 1'b0);
    end

    // Reset
    reset_n = 1'b0;
    step();
    step();
    model_reset();
    reset_n = 1'b1;
    for (int s = 0; s < 2; s++) begin
      check_status(s);
      check_hold(s);
    end
    fetch_cycle(0, 12'd0, 1'b1, 1'b0);   // IDLE fetch -> bubble

    // Basic load of four words, then fetch each
    load_cycle(0, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) load_cycle(0, 1'b0, 1'b1, prog[i], i == 3);
    for (int i = 0; i < 4; i++) fetch_cycle(0, 12'(i * 4), 1'b1, 1'b0);

    // Stall holds output while address moves, then re-enable
    fetch_cycle(0, 12'd8, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) fetch_cycle(0, 12'd12, 1'b0, 1'b0);
    fetch_cycle(0, 12'd12, 1'b1, 1'b0);

    // Flush overrides stall; misaligned fetch
    fetch_cycle(0, 12'd4, 1'b0, 1'b1);
    fetch_cycle(0, 12'd6, 1'b1, 1'b0);
    fetch_cycle(0, 12'd0, 1'b1, 1'b0);

    // Restart mid-stream; same-cycle beat 0xAA is discarded
    load_cycle(0, 1'b1, 1'b0, 32'h0, 1'b0);
    load_cycle(0, 1'b0, 1'b1, 32'hB0, 1'b0);
    load_cycle(0, 1'b0, 1'b1, 32'hB1, 1'b0);
    load_cycle(0, 1'b1, 1'b1, 32'hAA, 1'b0);
    load_cycle(0, 1'b0, 1'b1, 32'hC0, 1'b1);
    fetch_cycle(0, 12'd0, 1'b1, 1'b0);
    fetch_cycle(0, 12'd4, 1'b1, 1'b0);

    // Small instance: six beats without load_last, only four accepted
    load_cycle(1, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) load_cycle(1, 1'b0, 1'b1, 32'h50 + 32'(i), 1'b0);
    fetch_cycle(1, 12'd0, 1'b1, 1'b0);
    fetch_cycle(1, 12'd12, 1'b1, 1'b0);

    // Reset during a load abandons it; memory survives
    load_cycle(0, 1'b1, 1'b0, 32'h0, 1'b0);
    load_cycle(0, 1'b0, 1'b1, 32'hD0, 1'b0);
    drive_load(0, 1'b0, 1'b1, 32'hD1, 1'b0);
    reset_n = 1'b0;
    model_reset();
    step();
    reset_n = 1'b1;
    drive_load(0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int s = 0; s < 2; s++) begin
      check_status(s);
      check_hold(s);
    end
    fetch_cycle(0, 12'd0, 1'b1, 1'b0);
    load_cycle(0, 1'b1, 1'b0, 32'h0, 1'b0);
    load_cycle(0, 1'b0, 1'b1, 32'hE0, 1'b1);
    fetch_cycle(0, 12'd0, 1'b1, 1'b0);
    fetch_cycle(0, 12'd4, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_memory.md
# instruction_fetch_memory

Parametrised synchronous instruction store for the fetch stage, with a streaming program-load port and pipeline stall/flush control. Software or the test bench loads the program through a valid/ready word stream with an auto-incrementing write pointer. After loading, the block serves one-cycle-latency fetches addressed by byte PC. Stall holds the output; flush and misaligned fetches return a NOP bubble.

## Interface
Parameters:
- DATA_WIDTH, 32: instruction word width in bits.
- ADDR_WIDTH, 10: word-index width; depth is 2**ADDR_WIDTH words.
- NOP_WORD, 32'h0000_0000: word driven on bubbles; width DATA_WIDTH.

Ports:
- system_clock  in  1  sole clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- load_start  in  1  one-cycle pulse; enters LOADING and sets the write pointer to 0.
- load_valid  in  1  a load word is present.
- load_data  in  DATA_WIDTH  word to write.
- load_last  in  1  marks the final word of the program.
- load_ready  out  1  equals (state == LOADING); combinational from state.
- words_loaded  out  ADDR_WIDTH+1  count of words written since the last load_start.
- loaded  out  1  high in READY.
- fetch_address  in  ADDR_WIDTH+2  byte address; word index is fetch_address[ADDR_WIDTH+1:2].
- fetch_enable  in  1  1 = advance; 0 = stall (hold outputs).
- flush  in  1  replaces the next output with a bubble.
- data_out  out  DATA_WIDTH  fetched instruction, registered.
- data_valid  out  1  data_out is a real instruction.
- fetch_misaligned  out  1  registered; set for an enabled fetch with fetch_address[1:0] != 0.

## Operation
State machine:
- IDLE: entered on reset. Fetches return bubbles.
- LOADING: entered on load_start from any state.
- READY: entered from LOADING after the final write.

Transitions:
- load_start in any state goes to LOADING, with write pointer := 0 and words_loaded := 0.
- load_start has priority over a same-cycle load_valid; that beat is discarded and not written.
- In LOADING, each cycle with load_valid && load_ready and no load_start does three things:
  - writes memory[ptr] := load_data;
  - increments ptr;
  - increments words_loaded.
- A write with load_last = 1 goes to READY.
- A write to index 2**ADDR_WIDTH-1 goes to READY, regardless of load_last. The pointer never wraps, and no further writes occur.

Fetch register update each cycle, in priority order:
1. Reset: data_out := 0, data_valid := 0, fetch_misaligned := 0.
2. flush = 1: data_out := NOP_WORD, data_valid := 0, fetch_misaligned := 0. Flush overrides stall.
3. fetch_enable = 0: all fetch outputs hold.
4. State is not READY: data_out := NOP_WORD, data_valid := 0, fetch_misaligned := 0.
5. fetch_address[1:0] != 0: data_out := NOP_WORD, data_valid := 0, fetch_misaligned := 1.
6. Otherwise: data_out := memory[word index], data_valid := 1, fetch_misaligned := 0.

Other rules:
- Memory contents are not cleared by reset; only control state resets.
- Unwritten locations read as whatever the array holds. The bench must not rely on their value.

## Timing
Reset (reset_n sampled low at a rising edge):
- Next cycle: state = IDLE, ptr = 0, words_loaded = 0, loaded = 0, load_ready = 0, data_out = 0, data_valid = 0, fetch_misaligned = 0.
- Reset mid-load abandons the load. Words already written remain in memory.

Latency and handshake:
- Fetch latency is 1 cycle: address presented at edge N appears on data_out after edge N+1.
- Load throughput is one word per cycle; load_ready never drops inside LOADING.
- Last-word write at edge N: loaded = 1 and load_ready = 0 after edge N. A fetch presented at edge N+1 is served from memory.

Read/write interaction:
- Reads and writes cannot conflict, because fetches are served only in READY and writes occur only in LOADING.
- load_start while READY drops loaded to 0 the next cycle. Outputs already registered stay until the next enabled fetch or flush.

## Test plan
- Reset, then load_start, then 4 words 0x11,0x22,0x33,0x44 with load_last on the 4th -> words_loaded = 4, loaded = 1; fetches at addresses 0,4,8,12 return those words, each with data_valid = 1 one cycle later.
- Fetch address 8 returning 0x33; then fetch_enable = 0 for 3 cycles while the address changes to 12 -> data_out stays 0x33 with valid = 1; re-enable -> 0x44 next cycle.
- flush together with fetch_enable = 0 at address 4 -> next cycle data_out = NOP_WORD, data_valid = 0. Fetch address 6 -> fetch_misaligned = 1, data_valid = 0.
- ADDR_WIDTH = 2; stream 6 words without load_last -> only 4 words written, READY after the 4th write; load_ready low for the remaining 2 beats; words_loaded = 4.
- load_start asserted mid-stream after 2 words, in the same cycle as load_valid carrying 0xAA -> 0xAA not written; ptr = 0; the next word lands at index 0.
- reset_n low during LOADING -> IDLE; fetch at address 0 returns NOP_WORD with valid = 0; previously written words are readable again after a fresh load of length 1 leaves index 1 untouched.
